// File: rtl/uart_rx_if.sv
// Receiver-side handshake bundle: baud tick, serial line, and the holding-register
// outputs with their consumer ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick;
  logic                 rx;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  tick,
    input  rx,
    input  ready,
    output data,
    output valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output tick,
    output rx,
    output ready,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first data capture,
// stop-bit check with break handling, and a one-deep holding register with overrun reporting.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      i_clkin,
  input  logic      i_reset,
  uart_rx_if.slave  io_bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [TW-1:0]         r_tick_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  r_busy;

  logic                  w_half;
  logic                  w_full;
  logic                  w_stop_ok;

  assign w_half    = io_bus.tick && (r_tick_cnt == HALF_M1);
  assign w_full    = io_bus.tick && (r_tick_cnt == FULL_M1);
  assign w_stop_ok = (r_state == S_STOP) && w_full && r_rx_s;

  // The line idles high, so both synchronizer stages reset to 1 to avoid a false start.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= io_bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_tick_cnt <= '0;
            r_state    <= S_START;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_half) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            if (!r_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (io_bus.tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_tick_cnt <= '0;
            r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= S_STOP;
            end
          end else if (io_bus.tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_full) begin
            r_tick_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else if (io_bus.tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A completed byte may replace the held one only when the consumer takes it in the same cycle.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_stop_ok) begin
        if (!r_valid || io_bus.ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && io_bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.data      = r_data;
  assign io_bus.valid     = r_valid;
  assign io_bus.frame_err = r_frame_err;
  assign io_bus.overrun   = r_overrun;
  assign io_bus.busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames, hand-timed handshake and
// reset sequences, and random frames checked against a queue-based reference model.
module tb_uart_rx;
  localparam int DB = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.DATA_BITS(DB)) u_if();

  uart_rx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .i_clkin(clk),
    .i_reset(rst),
    .io_bus (u_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Baud tick: one pulse every tick_period cycles, changed only between frames.
  int tick_period = 1;
  int tick_div    = 0;
  always @(posedge clk) begin
    #1;
    if (tick_div >= tick_period - 1) begin
      tick_div  = 0;
      u_if.tick = 1'b1;
    end else begin
      tick_div  = tick_div + 1;
      u_if.tick = 1'b0;
    end
  end

  // Observer: accepted words and pulse/cycle counts, sampled on the falling edge.
  logic [DB-1:0] acc_q[$];
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vcyc = 0, busy_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.valid) vcyc = vcyc + 1;
      if (u_if.valid && u_if.ready) acc_q.push_back(u_if.data);
      if (u_if.frame_err) fe_cnt = fe_cnt + 1;
      if (u_if.overrun) ov_cnt = ov_cnt + 1;
      if (u_if.frame_err && u_if.overrun) both_cnt = both_cnt + 1;
      if (u_if.busy) busy_cyc = busy_cyc + 1;
    end
  end

  int b_acc, b_fe, b_ov, b_vcyc, b_busy;

  task automatic snap();
    b_acc  = acc_q.size();
    b_fe   = fe_cnt;
    b_ov   = ov_cnt;
    b_vcyc = vcyc;
    b_busy = busy_cyc;
  endtask

  function automatic logic [DB-1:0] last_acc();
    if (acc_q.size() == 0) return '0;
    return acc_q[acc_q.size() - 1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (u_if.tick) c++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_lvl, input int stop_ticks);
    u_if.rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      u_if.rx = d[i];
      wait_ticks(OS);
    end
    u_if.rx = stop_lvl;
    wait_ticks(stop_ticks);
    u_if.rx = 1'b1;
  endtask

  typedef struct {
    logic [DB-1:0] din;
    logic          stop_ok;
    logic [DB-1:0] exp_data;
    int            exp_acc;
    int            exp_fe;
  } vec_t;

  vec_t vecs[6];
  logic [DB-1:0] exp_q[$];

  initial begin
    int k;
    int exp_fe;
    logic [DB-1:0] d;
    logic bad;

    u_if.rx    = 1'b1;
    u_if.ready = 1'b0;
    rst        = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_data", 32'(u_if.data), 32'h0);
    chk("reset_valid", 32'(u_if.valid), 32'h0);
    chk("reset_busy", 32'(u_if.busy), 32'h0);
    chk("reset_frame_err", 32'(u_if.frame_err), 32'h0);
    chk("reset_overrun", 32'(u_if.overrun), 32'h0);
    rst = 1'b0;
    wait_ticks(OS);

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[5] = '{8'h3C, 1'b0, 8'h00, 0, 1};

    u_if.ready = 1'b1;
    foreach (vecs[i]) begin
      snap();
      send_frame(vecs[i].din, vecs[i].stop_ok, OS);
      wait_ticks(2 * OS);
      $display("vector %0d: din=0x%0h stop_ok=%0b", i, vecs[i].din, vecs[i].stop_ok);
      chk("vec_accepted", 32'(acc_q.size() - b_acc), 32'(vecs[i].exp_acc));
      chk("vec_valid_cycles", 32'(vcyc - b_vcyc), 32'(vecs[i].exp_acc));
      if (vecs[i].exp_acc == 1) chk("vec_data", 32'(last_acc()), 32'(vecs[i].exp_data));
      chk("vec_frame_err", 32'(fe_cnt - b_fe), 32'(vecs[i].exp_fe));
      chk("vec_overrun", 32'(ov_cnt - b_ov), 32'h0);
      chk("vec_valid_end", 32'(u_if.valid), 32'h0);
    end

    // Short low glitch: start qualification must reject it.
    snap();
    u_if.rx = 1'b0;
    wait_ticks(4);
    u_if.rx = 1'b1;
    k = 0;
    while (u_if.busy && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("glitch_busy_fall", 32'(u_if.busy), 32'h0);
    chk("glitch_busy_rose", 32'(busy_cyc > b_busy), 32'h1);
    chk("glitch_valid", 32'(u_if.valid), 32'h0);
    wait_ticks(OS);
    chk("glitch_accepted", 32'(acc_q.size() - b_acc), 32'h0);

    // Long break after 0x3C, then 0x81 once the line returns high.
    snap();
    send_frame(8'h3C, 1'b0, 40);
    chk("break_busy", 32'(u_if.busy), 32'h1);
    chk("break_frame_err", 32'(fe_cnt - b_fe), 32'h1);
    chk("break_valid", 32'(u_if.valid), 32'h0);
    wait_ticks(OS);
    chk("break_exit_busy", 32'(u_if.busy), 32'h0);
    send_frame(8'h81, 1'b1, OS);
    wait_ticks(OS);
    chk("break_next_count", 32'(acc_q.size() - b_acc), 32'h1);
    chk("break_next_data", 32'(last_acc()), 32'h81);
    chk("break_fe_total", 32'(fe_cnt - b_fe), 32'h1);

    // Back-to-back frames with the consumer stalled.
    u_if.ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, OS);
    send_frame(8'h22, 1'b1, OS);
    wait_ticks(OS);
    chk("ovr_data", 32'(u_if.data), 32'h11);
    chk("ovr_valid", 32'(u_if.valid), 32'h1);
    chk("ovr_pulses", 32'(ov_cnt - b_ov), 32'h1);
    chk("ovr_frame_err", 32'(fe_cnt - b_fe), 32'h0);
    u_if.ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.ready = 1'b0;
    chk("ovr_drain_valid", 32'(u_if.valid), 32'h0);
    chk("ovr_drain_data", 32'(last_acc()), 32'h11);

    // Accept in the exact cycle the next byte completes: replace without overrun.
    snap();
    send_frame(8'h11, 1'b1, OS);
    wait_ticks(OS);
    chk("swap_hold_data", 32'(u_if.data), 32'h11);
    chk("swap_hold_valid", 32'(u_if.valid), 32'h1);
    fork
      send_frame(8'h22, 1'b1, OS);
      begin
        // Start seen 3 edges after rx falls, 8 ticks to mid-start, 8x16 data, 16 to mid-stop.
        repeat (154) @(posedge clk);
        #1;
        u_if.ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.ready = 1'b0;
        chk("swap_overrun", 32'(ov_cnt - b_ov), 32'h0);
        chk("swap_valid", 32'(u_if.valid), 32'h1);
        chk("swap_data", 32'(u_if.data), 32'h22);
      end
    join
    chk("swap_taken", 32'(last_acc()), 32'h11);

    // Reset in the middle of bit 3 of 0xFF while 0x22 is still held.
    snap();
    u_if.rx = 1'b0;
    wait_ticks(OS);
    u_if.rx = 1'b1;
    wait_ticks(3 * OS + OS / 2);
    chk("rst_mid_busy", 32'(u_if.busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_data", 32'(u_if.data), 32'h0);
    chk("rst_mid_valid", 32'(u_if.valid), 32'h0);
    chk("rst_mid_busy0", 32'(u_if.busy), 32'h0);
    chk("rst_mid_fe", 32'(u_if.frame_err), 32'h0);
    chk("rst_mid_ov", 32'(u_if.overrun), 32'h0);
    rst = 1'b0;
    wait_ticks(OS / 2 + 5 * OS);
    u_if.ready = 1'b1;
    snap();
    send_frame(8'h5A, 1'b1, OS);
    wait_ticks(OS);
    chk("rst_next_count", 32'(acc_q.size() - b_acc), 32'h1);
    chk("rst_next_data", 32'(last_acc()), 32'h5A);

    // Random frames: every good frame must come out in order, every bad stop is one frame_err.
    snap();
    exp_fe = 0;
    for (int f = 0; f < 25; f++) begin
      tick_period = $urandom_range(1, 3);
      d   = DB'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      $display("random frame %0d: data=0x%0h bad_stop=%0b tick_period=%0d", f, d, bad, tick_period);
      if (bad) begin
        send_frame(d, 1'b0, OS);
        exp_fe++;
        wait_ticks(OS * $urandom_range(1, 3));
      end else begin
        send_frame(d, 1'b1, OS);
        exp_q.push_back(d);
        wait_ticks(OS * $urandom_range(0, 3));
      end
    end
    wait_ticks(2 * OS);
    tick_period = 1;
    chk("rand_count", 32'(acc_q.size() - b_acc), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b_acc + i < acc_q.size()) chk("rand_data", 32'(acc_q[b_acc + i]), 32'(exp_q[i]));
    end
    chk("rand_frame_err", 32'(fe_cnt - b_fe), 32'(exp_fe));
    chk("rand_overrun", 32'(ov_cnt - b_ov), 32'h0);
    chk("never_both_pulses", 32'(both_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "simulation timeout");
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (range 5..9).
REQ-002 Parameter OVERSAMPLE, default 16, number of tick pulses per bit period (even, >=4).
REQ-003 CLKIN  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle strobe from the baud generator at OVERSAMPLE x bit rate.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 data  output  DATA_BITS  last received byte; valid only while valid=1.
REQ-008 valid  output  1  holding register occupied.
REQ-009 ready  input  1  consumer accepts data on a cycle with valid=1 and ready=1.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL pass rx through a two-flop synchronizer (rx_s) and SHALL use only rx_s internally.
REQ-014 States SHALL be IDLE, START, DATA, STOP and BREAK; the tick counter SHALL be clog2(OVERSAMPLE) bits wide and the bit counter clog2(DATA_BITS+1) bits wide.
REQ-015 IDLE: when rx_s=0, the block SHALL clear the tick counter and enter START on the next edge, whether or not tick is asserted.
REQ-016 START: on the (OVERSAMPLE/2)th tick, the block SHALL sample rx_s; 0 -> DATA with counters cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: on every OVERSAMPLE-th tick, the block SHALL shift rx_s into the shift register LSB first and increment the bit counter; after DATA_BITS samples it SHALL enter STOP.
REQ-018 STOP: on the OVERSAMPLE-th tick, rx_s=1 SHALL trigger delivery (REQ-020) and a transition to IDLE; rx_s=0 SHALL pulse frame_err for one cycle, discard the byte and enter BREAK.
REQ-019 BREAK: the block SHALL remain in BREAK until rx_s=1, then enter IDLE; no start bit SHALL be detected while in BREAK.
REQ-020 Delivery: if valid=0, or valid=1 and ready=1 in the same cycle, data SHALL load the shift register and valid SHALL be 1 on the next edge; otherwise overrun SHALL pulse for one cycle and data/valid SHALL remain unchanged.
REQ-021 When valid=1, ready=1 and no delivery occurs in that cycle, valid SHALL be 0 on the next edge; data SHALL hold its value until the next load.
REQ-022 When tick is low, the tick counter, bit counter and state SHALL hold, except for the transitions in REQ-015 and REQ-019.
REQ-023 frame_err and overrun SHALL never be asserted in the same cycle, and neither SHALL be asserted for more than one cycle per frame.

Reset
REQ-024 While RESET=1 at an edge, state SHALL become IDLE, all counters and the shift register 0, both synchronizer flops 1, and data=0, valid=0, frame_err=0, overrun=0, busy=0.
REQ-025 RESET SHALL override tick, rx and ready, including mid-frame and mid-handshake; the partial byte SHALL be discarded.

Verification
REQ-026 The bench SHALL cover: OVERSAMPLE=16, tick every cycle, frame 0xA5 with a good stop bit, ready=1 -> exactly one valid cycle with data=0xA5; frame_err=0 and overrun=0.
REQ-027 The bench SHALL cover: rx low for 4 ticks, then high -> START returns to IDLE, valid stays 0, and busy falls within 8 ticks.
REQ-028 The bench SHALL cover: frame 0x3C with the stop bit held low for 40 ticks -> one frame_err pulse and valid=0; a subsequent frame 0x81 is not recognized until rx_s=1, after which data=0x81.
REQ-029 The bench SHALL cover: ready=0, then frames 0x11 and 0x22 back to back -> data=0x11 with valid=1, one overrun pulse at the 0x22 stop bit; then ready=1 for one cycle -> valid=0.
REQ-030 The bench SHALL cover: valid=1 holding 0x11 with ready=1 in the exact cycle that 0x22 completes -> no overrun pulse, and data=0x22 with valid=1 on the next edge.
REQ-031 The bench SHALL cover: RESET pulsed during bit 3 of frame 0xFF -> all outputs 0 on the next edge; a following frame 0x5A is received correctly as 0x5A.
